// File: rtl/rv_alu_pkg.sv
// Shared types for the rv_alu_seq execute unit: op codes, FSM states and constants.
package rv_alu_pkg;

    localparam int LUI_SHIFT = 12;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_LUI    = 5'd10,
        OP_BEQ    = 5'd11,
        OP_BNE    = 5'd12,
        OP_BLT    = 5'd13,
        OP_BGE    = 5'd14,
        OP_BLTU   = 5'd15,
        OP_BGEU   = 5'd16,
        OP_MUL    = 5'd17,
        OP_MULH   = 5'd18,
        OP_MULHSU = 5'd19,
        OP_MULHU  = 5'd20,
        OP_DIV    = 5'd21,
        OP_DIVU   = 5'd22,
        OP_REM    = 5'd23,
        OP_REMU   = 5'd24
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXEC   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_MULDIV = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    function automatic logic is_shift_op(input alu_op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/rv_alu_muldiv_seq.sv
// Iterative RV-M unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Divide-by-zero and signed overflow are resolved at start and report done one cycle later.
module rv_alu_muldiv_seq
    import rv_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  alu_op_e         i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic            r_run;
    logic [CW-1:0]   r_cnt;
    alu_op_e         r_op;
    logic            r_div;
    logic            r_neg;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opnd;

    logic            w_div, w_rem_op, w_a_neg, w_b_neg, w_div0, w_ovf;
    logic [XLEN-1:0] w_a_abs, w_b_abs;
    logic [XLEN:0]   w_sum, w_trial;
    logic [XLEN-1:0] w_diff;
    logic            w_ge;
    logic [2*XLEN-1:0] w_prod;

    always_comb begin
        w_div    = i_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        w_rem_op = i_op inside {OP_REM, OP_REMU};
        w_a_neg  = (i_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && i_a[XLEN-1];
        w_b_neg  = (i_op inside {OP_MULH, OP_DIV, OP_REM}) && i_b[XLEN-1];
        w_a_abs  = w_a_neg ? -i_a : i_a;
        w_b_abs  = w_b_neg ? -i_b : i_b;
        w_div0   = w_div && (i_b == '0);
        w_ovf    = (i_op inside {OP_DIV, OP_REM}) && (i_a == MIN_VAL) && (i_b == '1);
    end

    // Multiply accumulates into r_hi while shifting the multiplier out of r_lo;
    // divide shifts the dividend out of r_lo into the remainder in r_hi.
    always_comb begin
        w_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : '0)};
        w_trial = {r_hi, r_lo[XLEN-1]};
        w_ge    = w_trial >= {1'b0, r_opnd};
        w_diff  = w_trial[XLEN-1:0] - r_opnd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run  <= 1'b0;
            r_cnt  <= '0;
            r_op   <= OP_ADD;
            r_div  <= 1'b0;
            r_neg  <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
        end else if (i_start) begin
            r_run <= 1'b1;
            r_op  <= i_op;
            r_div <= w_div;
            if (w_div0) begin
                r_hi  <= i_a;
                r_lo  <= '1;
                r_neg <= 1'b0;
                r_cnt <= '0;
            end else if (w_ovf) begin
                r_hi  <= '0;
                r_lo  <= MIN_VAL;
                r_neg <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_hi   <= '0;
                r_lo   <= w_div ? w_a_abs : w_b_abs;
                r_opnd <= w_div ? w_b_abs : w_a_abs;
                r_neg  <= w_rem_op ? w_a_neg : (w_a_neg ^ w_b_neg);
                r_cnt  <= CW'(XLEN);
            end
        end else if (r_run) begin
            if (r_cnt == '0) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
                if (r_div) begin
                    r_hi <= w_ge ? w_diff : w_trial[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], w_ge};
                end else begin
                    {r_hi, r_lo} <= {w_sum, r_lo[XLEN-1:1]};
                end
            end
        end
    end

    assign o_done = r_run && (r_cnt == '0);

    always_comb begin
        w_prod   = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
        o_result = '0;
        case (r_op)
            OP_MUL:                          o_result = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:    o_result = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:                 o_result = r_neg ? -r_lo : r_lo;
            OP_REM, OP_REMU:                 o_result = r_neg ? -r_hi : r_hi;
            default:                         o_result = '0;
        endcase
    end

endmodule

// File: rtl/rv_alu_seq.sv
// Handshaked multi-cycle execute unit: single-cycle ALU/branch/LUI, serial shifter,
// optional iterative multiply/divide enabled by defining RV_ALU_MULDIV_EN.
//
// state     | meaning
// ST_IDLE   | waiting for an op
// ST_EXEC   | single-cycle op (incl. undefined codes) computes its result
// ST_SHIFT  | serial shifter, up to SHIFT_STEP bits per cycle
// ST_MULDIV | waiting on the iterative multiply/divide unit
// ST_DONE   | result held with out_valid until out_ready
module rv_alu_seq
    import rv_alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_branch_taken,
    output logic            o_busy
);

    localparam int SHW = $clog2(XLEN);
    localparam int STW = $clog2(SHIFT_STEP + 1);

    state_e          r_state, w_state_nxt, w_start_state;
    alu_op_e         r_op, w_in_op;
    logic [XLEN-1:0] r_a, r_b, r_result;
    logic [SHW-1:0]  r_cnt;
    logic            r_taken;

    logic            w_accept;
    logic [STW-1:0]  w_step_amt;
    logic [XLEN-1:0] w_shifted, w_exec_result;
    logic            w_exec_taken;

`ifdef RV_ALU_MULDIV_EN
    logic            w_is_md, w_md_done;
    logic [XLEN-1:0] w_md_result;

    assign w_is_md = w_in_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                                     OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    rv_alu_muldiv_seq #(.XLEN(XLEN)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_accept && w_is_md),
        .i_op     (w_in_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );
`endif

    assign w_in_op = alu_op_e'(i_op);
    // A held result can be drained and the next op accepted on the same edge.
    assign o_in_ready     = (r_state == ST_IDLE) || ((r_state == ST_DONE) && i_out_ready);
    assign w_accept       = i_in_valid && o_in_ready;
    assign o_out_valid    = (r_state == ST_DONE);
    assign o_busy         = (r_state != ST_IDLE);
    assign o_result       = r_result;
    assign o_branch_taken = r_taken;

    always_comb begin
        w_start_state = is_shift_op(w_in_op) ? ST_SHIFT : ST_EXEC;
`ifdef RV_ALU_MULDIV_EN
        if (w_is_md) w_start_state = ST_MULDIV;
`endif
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = w_start_state;
            ST_EXEC:   w_state_nxt = ST_DONE;
            ST_SHIFT:  if (r_cnt == '0) w_state_nxt = ST_DONE;
`ifdef RV_ALU_MULDIV_EN
            ST_MULDIV: if (w_md_done) w_state_nxt = ST_DONE;
`endif
            ST_DONE: begin
                if (w_accept)         w_state_nxt = w_start_state;
                else if (i_out_ready) w_state_nxt = ST_IDLE;
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        if (int'(r_cnt) >= SHIFT_STEP) w_step_amt = STW'(SHIFT_STEP);
        else                           w_step_amt = STW'(r_cnt);
        case (r_op)
            OP_SLL:  w_shifted = r_a << w_step_amt;
            OP_SRL:  w_shifted = r_a >> w_step_amt;
            OP_SRA:  w_shifted = $signed(r_a) >>> w_step_amt;
            default: w_shifted = r_a;
        endcase
    end

    always_comb begin
        w_exec_result = '0;
        w_exec_taken  = 1'b0;
        case (r_op)
            OP_ADD:  w_exec_result = r_a + r_b;
            OP_SUB:  w_exec_result = r_a - r_b;
            OP_SLT:  w_exec_result[0] = $signed(r_a) < $signed(r_b);
            OP_SLTU: w_exec_result[0] = r_a < r_b;
            OP_XOR:  w_exec_result = r_a ^ r_b;
            OP_OR:   w_exec_result = r_a | r_b;
            OP_AND:  w_exec_result = r_a & r_b;
            OP_LUI:  w_exec_result = r_b << LUI_SHIFT;
            OP_BEQ:  w_exec_taken = r_a == r_b;
            OP_BNE:  w_exec_taken = r_a != r_b;
            OP_BLT:  w_exec_taken = $signed(r_a) < $signed(r_b);
            OP_BGE:  w_exec_taken = $signed(r_a) >= $signed(r_b);
            OP_BLTU: w_exec_taken = r_a < r_b;
            OP_BGEU: w_exec_taken = r_a >= r_b;
            default: ;
        endcase
    end

    // r_a doubles as the shift accumulator; r_cnt counts remaining shift bits down to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_taken  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= w_in_op;
                r_a   <= i_a;
                r_b   <= i_b;
                r_cnt <= i_b[SHW-1:0];
            end
            case (r_state)
                ST_EXEC: begin
                    r_result <= w_exec_result;
                    r_taken  <= w_exec_taken;
                end
                ST_SHIFT: begin
                    if (r_cnt == '0) begin
                        r_result <= r_a;
                        r_taken  <= 1'b0;
                    end else begin
                        r_a   <= w_shifted;
                        r_cnt <= r_cnt - SHW'(w_step_amt);
                    end
                end
`ifdef RV_ALU_MULDIV_EN
                ST_MULDIV: begin
                    if (w_md_done) begin
                        r_result <= w_md_result;
                        r_taken  <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
